sr_ifetch: RTL

- Instruction prefetch stage between the sr_cpu instruction port (imAddr/imData) and a multi-cycle, pipelined instruction memory with request/ack and in-order read-valid.
- Fetches sequential word addresses ahead of the CPU into a small tagged FIFO.
- Presents the instruction for the CPU's current word address with a valid flag, and flushes on any non-sequential address (branch).
- The CPU stalls its PC while cpuValid is low.

---
 rtl/sr_ifetch_pkg.sv | 6 +
 rtl/sr_ifetch_fifo.sv | 51 +++++
 rtl/sr_ifetch.sv | 82 ++++++++
 3 files changed

// File: rtl/sr_ifetch_pkg.sv
// sr_ifetch_pkg: shared defaults and types for the instruction prefetch stage
package sr_ifetch_pkg;
    localparam int SR_IFETCH_DEPTH = 4;
    localparam int SR_IFETCH_AW = 32;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/sr_ifetch_fifo.sv
// sr_ifetch_fifo: DEPTH x 32 synchronous FIFO with registered head word
//   clk, rst_n     : clock, synchronous active-low reset
//   push/wdata     : write one word
//   pop            : drop the head word
//   clear          : empty the FIFO (wins over push/pop)
//   count          : number of stored words
//   head           : registered head word, 0 while empty
module sr_ifetch_fifo
    import sr_ifetch_pkg::*;
#(
    parameter int DEPTH = SR_IFETCH_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  word_t                    wdata,
    output logic [$clog2(DEPTH):0]   count,
    output word_t                    head
);
    localparam int PW = $clog2(DEPTH);

    word_t          mem [DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;
    logic [PW-1:0]  rdNext;
    logic [PW:0]    countNext;

    assign rdNext    = rdPtr + PW'(pop);
    assign countNext = count + (PW+1)'(push) - (PW+1)'(pop);

    always_ff @(posedge clk)
        if (push) mem[wrPtr] <= wdata;

    // head is precomputed from next-cycle state; when the only word left
    // after this cycle is the one being pushed, it comes straight from wdata
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            head  <= '0;
        end else begin
            wrPtr <= wrPtr + PW'(push);
            rdPtr <= rdNext;
            count <= countNext;
            head  <= countNext == '0 ? '0 : (count == (PW+1)'(pop) ? wdata : mem[rdNext]);
        end
    end
endmodule

// File: rtl/sr_ifetch.sv
// sr_ifetch: sequential instruction prefetch between the CPU fetch port and a pipelined memory
//   clk, rst_n         : clock, synchronous active-low reset
//   cpuAddr            : word address the CPU wants now
//   cpuData, cpuValid  : instruction for cpuAddr and its valid flag
//   cpuTake            : CPU consumes the head instruction
//   memReq, memAddr    : fetch request and its word address
//   memAck             : request accepted
//   memRvalid, memRdata: in-order read return, one per accepted request
module sr_ifetch
    import sr_ifetch_pkg::*;
#(
    parameter int DEPTH = SR_IFETCH_DEPTH,
    parameter int AW    = SR_IFETCH_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpuAddr,
    output logic [31:0]   cpuData,
    output logic          cpuValid,
    input  logic          cpuTake,
    output logic          memReq,
    output logic [AW-1:0] memAddr,
    input  logic          memAck,
    input  logic          memRvalid,
    input  logic [31:0]   memRdata
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] headAddr;
    logic [AW-1:0] reqPtr;
    logic [CW-1:0] count;
    logic [CW-1:0] live;
    logic [CW-1:0] discard;
    logic [CW:0]   occupancy;
    logic          mismatch;
    logic          accept;
    logic          push;
    logic          drop;
    logic          take;

    assign mismatch  = cpuAddr != headAddr;
    assign occupancy = {1'b0, count} + {1'b0, live};
    // buffered plus in-flight words reserve FIFO space, so pushes never overflow
    assign memReq    = rst_n && !mismatch && occupancy < (CW+1)'(DEPTH);
    assign memAddr   = reqPtr;
    assign cpuValid  = !mismatch && count != '0;
    assign take      = cpuTake && cpuValid;
    assign accept    = memReq && memAck;
    assign push      = !mismatch && memRvalid && discard == '0;
    assign drop      = !mismatch && memRvalid && discard != '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            headAddr <= '0;
            reqPtr   <= '0;
            live     <= '0;
            discard  <= '0;
        end else if (mismatch) begin
            // everything still outstanding becomes stale; a return this cycle is already gone
            headAddr <= cpuAddr;
            reqPtr   <= cpuAddr;
            live     <= '0;
            discard  <= discard + live - CW'(memRvalid);
        end else begin
            headAddr <= headAddr + AW'(take);
            reqPtr   <= reqPtr + AW'(accept);
            live     <= live + CW'(accept) - CW'(push);
            discard  <= discard - CW'(drop);
        end
    end

    sr_ifetch_fifo #(.DEPTH(DEPTH)) fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (take),
        .clear(mismatch),
        .wdata(memRdata),
        .count(count),
        .head (cpuData)
    );
endmodule
